// File: rtl/snoop_pkg.sv
// Shared snoop-bus definitions: message field layout, op encodings, idle bus value
// and arbiter FSM states.
package snoop_pkg;

    localparam int OP_W     = 2;
    localparam int TAG_W    = 3;
    localparam int DATA_W   = 4;
    localparam int MSG_W    = 9;
    localparam int OP_LSB   = 7;
    localparam int TAG_LSB  = 4;
    localparam int DATA_LSB = 0;

    typedef enum logic [OP_W-1:0] {
        OP_READ_MISS  = 2'd0,
        OP_WRITE_BACK = 2'd1,
        OP_INVALIDATE = 2'd2,
        OP_NOP        = 2'd3
    } op_e;

    localparam logic [MSG_W-1:0] BUS_IDLE = 9'b11_000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic [OP_W-1:0] msg_op(input logic [MSG_W-1:0] m);
        return m[OP_LSB +: OP_W];
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin winner select: searches upward from i_last + 1,
// wrapping at NUM_CPU-1. With i_last tied to NUM_CPU-1 it becomes fixed priority.
module rr_arbiter #(
    parameter int NUM_CPU = 3,
    parameter int PTR_W   = $clog2(NUM_CPU)
) (
    input  logic [NUM_CPU-1:0] i_req,
    input  logic [PTR_W-1:0]   i_last,
    output logic [NUM_CPU-1:0] o_winner,
    output logic [PTR_W-1:0]   o_winner_idx
);

    // Walk the search order backwards so the earliest requester overwrites last.
    always_comb begin
        o_winner     = '0;
        o_winner_idx = '0;
        for (int k = NUM_CPU; k >= 1; k--) begin
            int sum;
            sum = int'(i_last) + k;
            if (sum >= NUM_CPU) begin
                sum = sum - NUM_CPU;
            end else begin
                sum = sum;
            end
            if (i_req[sum]) begin
                o_winner      = '0;
                o_winner[sum] = 1'b1;
                o_winner_idx  = PTR_W'(sum);
            end else begin
                o_winner     = o_winner;
                o_winner_idx = o_winner_idx;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Snoop-bus arbiter: IDLE -> XFER -> DONE transaction per grant, registered outputs.
// Define ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module bus_arbiter
    import snoop_pkg::*;
#(
    parameter int NUM_CPU = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_CPU-1:0]     req,
    input  logic [MSG_W*NUM_CPU-1:0] msg,
    output logic [NUM_CPU-1:0]     grant,
    output logic [MSG_W-1:0]       bus,
    input  logic [MSG_W-1:0]       mem_out,
    output logic [NUM_CPU-1:0]     done,
    output logic [DATA_W-1:0]      rdata
);

    localparam int PTR_W = $clog2(NUM_CPU);

    state_e               r_state;
    state_e               w_next_state;
    logic [NUM_CPU-1:0]   r_grant;
    logic [NUM_CPU-1:0]   w_grant_d;
    logic [MSG_W-1:0]     r_bus;
    logic [MSG_W-1:0]     w_bus_d;
    logic [NUM_CPU-1:0]   r_done;
    logic [NUM_CPU-1:0]   w_done_d;
    logic [DATA_W-1:0]    r_rdata;
    logic [DATA_W-1:0]    w_rdata_d;
    logic [NUM_CPU-1:0]   w_win;
    logic [PTR_W-1:0]     w_win_idx;
    logic [PTR_W-1:0]     w_last;
    logic [MSG_W-1:0]     w_sel_msg;
    logic                 w_unused_mem;

    assign w_unused_mem = ^mem_out[MSG_W-1:DATA_W];

`ifdef ARB_FIXED_PRIO_EN
    logic w_unused_idx;
    assign w_unused_idx = ^w_win_idx;
    assign w_last       = PTR_W'(NUM_CPU - 1);
`else
    logic [PTR_W-1:0] r_last;

    // Round-robin pointer advances to each new winner at grant time.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_last <= PTR_W'(NUM_CPU - 1);
        end else if ((r_state == ST_IDLE) && (|req)) begin
            r_last <= w_win_idx;
        end else begin
            r_last <= r_last;
        end
    end
    assign w_last = r_last;
`endif

    rr_arbiter #(
        .NUM_CPU (NUM_CPU),
        .PTR_W   (PTR_W)
    ) u_rr_arbiter (
        .i_req        (req),
        .i_last       (w_last),
        .o_winner     (w_win),
        .o_winner_idx (w_win_idx)
    );

    // Mux the winning controller's message slice out of the packed msg vector.
    always_comb begin
        w_sel_msg = BUS_IDLE;
        for (int i = 0; i < NUM_CPU; i++) begin
            if (w_win[i]) begin
                w_sel_msg = msg[i*MSG_W +: MSG_W];
            end else begin
                w_sel_msg = w_sel_msg;
            end
        end
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = ST_IDLE;
        case (r_state)
            ST_IDLE: begin
                if (|req) begin
                    w_next_state = ST_XFER;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_XFER: w_next_state = ST_DONE;
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Next output values; a no-op message is granted but keeps the bus idle.
    always_comb begin
        w_grant_d = r_grant;
        w_bus_d   = r_bus;
        w_done_d  = '0;
        w_rdata_d = r_rdata;
        case (r_state)
            ST_IDLE: begin
                if (|req) begin
                    w_grant_d = w_win;
                    w_bus_d   = (msg_op(w_sel_msg) == OP_NOP) ? BUS_IDLE : w_sel_msg;
                end else begin
                    w_grant_d = '0;
                    w_bus_d   = BUS_IDLE;
                end
            end
            ST_XFER: begin
                w_bus_d  = BUS_IDLE;
                w_done_d = r_grant;
                if (msg_op(r_bus) == OP_READ_MISS) begin
                    w_rdata_d = mem_out[DATA_W-1:0];
                end else begin
                    w_rdata_d = r_rdata;
                end
            end
            ST_DONE: begin
                w_grant_d = '0;
                w_bus_d   = BUS_IDLE;
            end
            default: begin
                w_grant_d = '0;
                w_bus_d   = BUS_IDLE;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_grant <= '0;
            r_bus   <= BUS_IDLE;
            r_done  <= '0;
            r_rdata <= '0;
        end else begin
            r_grant <= w_grant_d;
            r_bus   <= w_bus_d;
            r_done  <= w_done_d;
            r_rdata <= w_rdata_d;
        end
    end

    assign grant = r_grant;
    assign bus   = r_bus;
    assign done  = r_done;
    assign rdata = r_rdata;

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized self-checking bench for bus_arbiter against a transaction-level model.
module tb_bus_arbiter;

    localparam int          N    = 3;
    localparam logic [8:0]  IDLE = 9'h180;

    logic           clock;
    logic           reset;
    logic [N-1:0]   req;
    logic [9*N-1:0] msg;
    logic [8:0]     mem_out;
    logic [N-1:0]   grant;
    logic [8:0]     bus;
    logic [N-1:0]   done;
    logic [3:0]     rdata;

    bus_arbiter #(.NUM_CPU(N)) dut (
        .clock   (clock),
        .reset   (reset),
        .req     (req),
        .msg     (msg),
        .grant   (grant),
        .bus     (bus),
        .mem_out (mem_out),
        .done    (done),
        .rdata   (rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Expected per-cycle output records scheduled at grant time.
    typedef struct {
        logic [N-1:0] g;
        logic [8:0]   b;
        logic [N-1:0] d;
        logic         cap;
    } rec_t;

    rec_t         sched[$];
    int           last;
    logic [N-1:0] m_grant;
    logic [N-1:0] m_done;
    logic [8:0]   m_bus;
    logic [3:0]   m_rdata;
    logic [1:0]   m_op;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expd);
        checks++;
        if (obs !== expd) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, expd);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r);
`ifdef ARB_FIXED_PRIO_EN
        for (int i = 0; i < N; i++) if (r[i]) return i;
`else
        for (int k = 1; k <= N; k++) if (r[(last + k) % N]) return (last + k) % N;
`endif
        return 0;
    endfunction

    task automatic model_reset();
        sched.delete();
        last    = N - 1;
        m_grant = '0;
        m_done  = '0;
        m_bus   = IDLE;
        m_rdata = 4'h0;
        m_op    = 2'd3;
    endtask

    task automatic check_outputs();
        chk("grant", grant, m_grant);
        chk("bus", bus, m_bus);
        chk("done", done, m_done);
        chk("rdata", rdata, m_rdata);
        chk("onehot", (($countones(grant) > 1) || ($countones(done) > 1)) ? 1 : 0, 0);
    endtask

    task automatic set_msg(input int i, input logic [8:0] v);
        msg[9*i +: 9] = v;
    endtask

    // One clock edge: model consumes the pre-edge inputs, then outputs are compared.
    task automatic tick();
        logic [N-1:0]   r_s;
        logic [9*N-1:0] m_s;
        logic [8:0]     mo_s;
        logic [8:0]     sel;
        rec_t           rec;
        int             w;
        r_s  = req;
        m_s  = msg;
        mo_s = mem_out;
        @(posedge clock);
        if (sched.size() > 0) begin
            rec     = sched.pop_front();
            m_grant = rec.g;
            m_bus   = rec.b;
            m_done  = rec.d;
            if (rec.cap && m_op == 2'd0) m_rdata = mo_s[3:0];
        end else if (r_s != '0) begin
            w          = pick(r_s);
            last       = w;
            sel        = m_s[9*w +: 9];
            m_op       = sel[8:7];
            m_grant    = '0;
            m_grant[w] = 1'b1;
            m_bus      = (sel[8:7] == 2'd3) ? IDLE : sel;
            m_done     = '0;
            sched.push_back('{m_grant, IDLE, m_grant, 1'b1});
            sched.push_back('{'0, IDLE, '0, 1'b0});
        end else begin
            m_grant = '0;
            m_bus   = IDLE;
            m_done  = '0;
        end
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #2;
        model_reset();
        check_outputs();
        @(posedge clock);
        #1;
        check_outputs();
        reset = 1'b0;
    endtask

    task automatic wait_grant();
        for (int n = 0; n < 12; n++) begin
            tick();
            if (grant != '0) return;
        end
        chk("grant_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] exp_g;
        reset   = 1'b1;
        req     = '0;
        msg     = '0;
        mem_out = '0;
        do_reset();

        // single read miss
        set_msg(0, 9'h020);
        mem_out = 9'h005;
        req     = 3'b001;
        tick();
        chk("rd_bus", bus, 9'h020);
        chk("rd_grant", grant, 3'b001);
        tick();
        chk("rd_done", done, 3'b001);
        chk("rd_rdata", rdata, 4'h5);
        req[0] = 1'b0;
        tick();
        chk("rd_idle", bus, IDLE);

        // write-back leaves rdata alone
        set_msg(1, 9'h0DA);
        mem_out = 9'h00F;
        req     = 3'b010;
        tick();
        chk("wb_bus", bus, 9'h0DA);
        tick();
        chk("wb_done", done, 3'b010);
        chk("wb_rdata", rdata, 4'h5);
        chk("wb_bus_idle", bus, IDLE);
        req = '0;
        tick();

        // message latched at grant
        set_msg(0, 9'h020);
        mem_out = 9'h003;
        req     = 3'b001;
        tick();
        set_msg(0, 9'h1FF);
        req = '0;
        #4;
        chk("latch_bus", bus, 9'h020);
        tick();
        chk("latch_rdata", rdata, 4'h3);
        tick();
        tick();

        // arbitration order
        do_reset();
        for (int i = 0; i < N; i++) set_msg(i, 9'($urandom));
        req = 3'b111;
        for (int k = 0; k < 6; k++) begin
            wait_grant();
`ifdef ARB_FIXED_PRIO_EN
            exp_g = 3'b001;
`else
            exp_g = 3'b001 << (k % 3);
`endif
            chk("arb_order", grant, exp_g);
            tick();
`ifndef ARB_FIXED_PRIO_EN
            req[k % 3] = 1'b0;
`endif
            tick();
            if (k == 2) req = 3'b111;
        end
        req = '0;
        tick();
        tick();
        tick();

        // reset during XFER aborts the transaction
        req = 3'b001;
        wait_grant();
        do_reset();
        chk("rst_grant", grant, 0);
        chk("rst_bus", bus, 9'h180);
        chk("rst_done", done, 0);
        req = 3'b110;
        wait_grant();
        chk("rst_first_grant", grant, 3'b010);
        tick();
        req = '0;
        tick();

        // randomized traffic
        for (int c = 0; c < 400; c++) begin
            mem_out = 9'($urandom);
            for (int i = 0; i < N; i++) begin
                if (m_done[i]) begin
                    if ($urandom_range(0, 3) != 0) req[i] = 1'b0;
                end else if (!req[i] && $urandom_range(0, 2) == 0) begin
                    req[i] = 1'b1;
                    set_msg(i, 9'($urandom));
                end
                if ($urandom_range(0, 7) == 0) set_msg(i, 9'($urandom));
            end
            if (c == 200) do_reset();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter: NUM_CPU, 3, number of cache controllers sharing the snoop bus (2..8).
REQ-002 SHALL have port: clock  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: req  input  NUM_CPU  per-controller bus request, level.
REQ-005 SHALL have port: msg  input  9*NUM_CPU  per-controller bus message, slice i = msg[9i+8:9i]; fields [8:7] op, [6:4] tag, [3:0] data.
REQ-006 SHALL have port: grant  output  NUM_CPU  one-hot bus ownership, registered.
REQ-007 SHALL have port: bus  output  9  shared snoop bus driven to memory and snoopers, registered.
REQ-008 SHALL have port: mem_out  input  9  memory read response; bits [3:0] are read data.
REQ-009 SHALL have port: done  output  NUM_CPU  one-cycle completion pulse to the granted controller.
REQ-010 SHALL have port: rdata  output  4  read-miss data, valid in the done cycle, held until next capture.

Function
REQ-011 SHALL use op encoding 0 readMiss, 1 writeBack, 2 invalidate, 3 no-op; idle bus value 9'b11_000_0000.
REQ-012 SHALL implement FSM IDLE -> XFER -> DONE -> IDLE; XFER and DONE last exactly one cycle each.
REQ-013 In IDLE with req != 0: SHALL select winner w, set grant = onehot(w), latch bus <= msg slice w, enter XFER.
REQ-014 In IDLE with req == 0: SHALL hold bus idle, grant 0, stay IDLE.
REQ-015 Message SHALL be latched at grant; changes to msg or req during XFER/DONE SHALL NOT affect the transaction.
REQ-016 At end of XFER: bus <= idle value; if latched op == 0, rdata <= mem_out[3:0], else rdata unchanged; enter DONE.
REQ-017 In DONE: done[w] = 1 for that cycle only; grant held; grant cleared on return to IDLE.
REQ-018 Latency: req sampled cycle 0, bus valid cycle 1, done cycle 2, earliest next grant cycle 4.
REQ-019 Requester SHALL drop req upon done; req still high when IDLE samples is a new request.
REQ-020 Default arbitration SHALL be round-robin: search from last winner + 1 upward, wrapping NUM_CPU-1 -> 0.
REQ-021 Op 3 from a requester SHALL still be granted and completed (done pulse), bus carries idle value.
REQ-022 At most one grant bit and one done bit SHALL ever be set.

Reset
REQ-023 reset SHALL asynchronously force: state IDLE, grant 0, done 0, rdata 0, bus idle value, last-winner pointer NUM_CPU-1.
REQ-024 reset mid-transaction SHALL abort it: no done pulse, no rdata update; first post-reset grant goes to lowest requesting index.

Configuration
REQ-025 Macro ARB_FIXED_PRIO_EN: when defined, SHALL use fixed priority (lowest requesting index wins) and omit the round-robin pointer; when undefined, round-robin per REQ-020.

Structure
REQ-026 Package snoop_pkg SHALL hold op encodings, field widths/offsets (OP 2, TAG 3, DATA 4, MSG 9), idle bus constant, FSM state typedef.
REQ-027 Winner selection SHALL be sub-module rr_arbiter (combinational: req, last pointer -> one-hot winner), shared by both configurations.

Verification
REQ-028 Single read: req=3'b001, msg0=9'b00_010_0000, mem_out=9'h005 -> cycle 1 bus=9'h020, grant=001; cycle 2 done=001, rdata=4'h5.
REQ-029 Round-robin: req=3'b111 held, each requester dropping on its done -> grant order 0,1,2; re-raise all -> 0,1,2 again.
REQ-030 Write-back: req=3'b010, msg1=9'b01_101_1010 -> bus=9'h0DA one cycle, done=010, rdata unchanged, bus idle after.
REQ-031 Latching: msg0 changed to 9'h1FF during XFER -> bus keeps original latched value.
REQ-032 Reset mid-XFER: assert reset in XFER -> grant 0, bus 9'h180, no done pulse; release, req=3'b110 -> grant 010.
REQ-033 ARB_FIXED_PRIO_EN defined: req=3'b111 held, each requester re-raising req immediately after its done -> CPU0 wins every arbitration.
